// File: rtl/jtpang_obj.sv
// Pang object engine: CPU-visible object RAM, per-line sprite scan with ROM fetch,
// and a double line buffer read out (and erased) at pixel rate on the following line.
`timescale 1ns/1ps

module jtpang_obj #(
    parameter logic [8:0] HOFFSET = 9'd0,
    parameter int         ROMW    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pxl_cen,
    input  logic            hs,
    input  logic            flip,
    input  logic [7:0]      vf,
    input  logic [8:0]      hdump,
    input  logic            obj_cs,
    input  logic            wr_n,
    input  logic [8:0]      cpu_addr,
    input  logic [7:0]      cpu_dout,
    output logic [7:0]      obj_dout,
    output logic            rom_cs,
    output logic [ROMW-1:0] rom_addr,
    input  logic            rom_ok,
    input  logic [31:0]     rom_data,
    output logic [7:0]      obj_pxl
);

    typedef enum logic [2:0] {
        IDLE, READ, CHECK, FETCH0, DRAW0, FETCH1, DRAW1, NEXT
    } state_t;

    state_t      st, st_nx;

    logic [7:0]  obj_ram [0:511];
    logic [7:0]  lbuf    [0:1023];

    logic        hs_l;
    logic        line_start;
    logic        buf_sel;
    logic [7:0]  target;
    logic [6:0]  obj_n;
    logic [2:0]  cnt;

    logic [7:0]  b0, b1, b2, b3;
    logic [3:0]  row;
    logic [31:0] pix_word;

    logic [8:0]  scan_addr;
    logic [7:0]  scan_byte;
    logic [10:0] code;
    logic [3:0]  pal;
    logic [8:0]  xpos;
    logic [7:0]  row_raw;
    logic        hit;
    logic        half;
    logic        drawing;
    logic [3:0]  draw_pix;
    logic [8:0]  draw_addr_raw;
    logic [8:0]  draw_addr;
    logic [7:0]  draw_dest;
    logic        draw_en;
    logic [8:0]  disp_addr;

    assign line_start = hs & ~hs_l;

    // CPU side of the object RAM
    always_ff @(posedge clk) begin
        if (obj_cs && !wr_n) obj_ram[cpu_addr] <= cpu_dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obj_dout <= 8'd0;
        end else if (obj_cs) begin
            obj_dout <= obj_ram[cpu_addr];
        end
    end

    // Scan side: entry bytes are read asynchronously so READ takes exactly 4 cycles
    assign scan_addr = {obj_n, cnt[1:0]};
    assign scan_byte = obj_ram[scan_addr];

    assign code    = {b1[7:5], b0};
    assign pal     = b1[3:0];
    assign xpos    = {b1[4], b3};
    assign row_raw = target - b2;
    assign hit     = (row_raw[7:4] == 4'd0);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
        end else begin
            st <= st_nx;
        end
    end

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    st_nx = IDLE;
            READ:    if (cnt[1:0] == 2'd3) st_nx = CHECK;
            CHECK:   st_nx = hit ? FETCH0 : NEXT;
            FETCH0:  if (rom_ok) st_nx = DRAW0;
            DRAW0:   if (cnt == 3'd7) st_nx = FETCH1;
            FETCH1:  if (rom_ok) st_nx = DRAW1;
            DRAW1:   if (cnt == 3'd7) st_nx = NEXT;
            NEXT:    st_nx = (obj_n == 7'd127) ? IDLE : READ;
            default: st_nx = IDLE;
        endcase
        // A new line always wins: the old scan is abandoned wherever it was
        if (line_start) st_nx = READ;
    end

    // Scan control: line sync, buffer select, entry and cycle counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_l    <= 1'b0;
            buf_sel <= 1'b0;
            obj_n   <= 7'd0;
            cnt     <= 3'd0;
        end else begin
            hs_l <= hs;
            if (line_start) begin
                buf_sel <= ~buf_sel;
                obj_n   <= 7'd0;
                cnt     <= 3'd0;
            end else begin
                case (st)
                    READ:        cnt   <= (cnt[1:0] == 2'd3) ? 3'd0 : cnt + 3'd1;
                    DRAW0,
                    DRAW1:       cnt   <= cnt + 3'd1;
                    NEXT: begin
                                 obj_n <= obj_n + 7'd1;
                                 cnt   <= 3'd0;
                    end
                    default:     cnt   <= cnt;
                endcase
            end
        end
    end

    // Scan datapath: entry fields, row and fetched ROM word
    always_ff @(posedge clk) begin
        if (line_start) target <= vf + 8'd1;
        if (st == READ) begin
            case (cnt[1:0])
                2'd0:    b0 <= scan_byte;
                2'd1:    b1 <= scan_byte;
                2'd2:    b2 <= scan_byte;
                default: b3 <= scan_byte;
            endcase
        end
        if (st == CHECK) row <= flip ? ~row_raw[3:0] : row_raw[3:0];
        if ((st == FETCH0 || st == FETCH1) && rom_ok) pix_word <= rom_data;
    end

    assign half     = (st == FETCH1) || (st == DRAW1);
    assign rom_cs   = (st == FETCH0 || st == FETCH1) && !line_start;
    assign rom_addr = ROMW'({code, row, half});

    // Draw stage: one pixel per cycle into the half being built for the next line
    assign drawing       = (st == DRAW0 || st == DRAW1) && !line_start;
    assign draw_pix      = pix_word[{cnt, 2'b00} +: 4];
    assign draw_addr_raw = xpos + {5'd0, half, cnt};
    assign draw_addr     = flip ? ~draw_addr_raw : draw_addr_raw;
    assign draw_dest     = lbuf[{buf_sel, draw_addr}];
    assign draw_en       = drawing && (draw_pix != 4'hf) && (draw_dest[3:0] == 4'hf);

    // Display stage: read the other half and erase behind the beam
    assign disp_addr = hdump + HOFFSET;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) lbuf[i] <= 8'hff;
        end else begin
            if (draw_en) lbuf[{buf_sel, draw_addr}] <= {pal, draw_pix};
            if (pxl_cen) lbuf[{~buf_sel, disp_addr}] <= 8'hff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obj_pxl <= 8'hff;
        end else if (pxl_cen) begin
            obj_pxl <= lbuf[{~buf_sel, disp_addr}];
        end
    end

endmodule
